// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the sequencer and datapath: ALU opcodes, sequencer states,
// instruction field positions, the HALT word and the branch target table.
package cpu_sequencer_pkg;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OPC_MSB = 8;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned FA_MSB  = 5;
    localparam int unsigned FA_LSB  = 3;
    localparam int unsigned FB_MSB  = 2;
    localparam int unsigned FB_LSB  = 0;

    localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_XOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_RSL  = 3'd3,
        OP_MOV  = 3'd4,
        OP_LD   = 3'd5,
        OP_ST   = 3'd6,
        OP_BLQZ = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_COMMIT = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic              reg_wr;
        logic [REG_AW-1:0] wr_addr;
        logic              wb_mem;
        logic              mem_rd;
        logic              mem_wr;
    } commit_ctrl_t;

    // Branch targets selected by field B of a BLQZ
    function automatic logic [7:0] branch_target(input logic [REG_AW-1:0] idx);
        logic [7:0] t;
        case (idx)
            3'd0:    t = 8'h10;
            3'd1:    t = 8'h18;
            3'd2:    t = 8'h20;
            3'd3:    t = 8'h40;
            3'd4:    t = 8'h08;
            3'd5:    t = 8'hF0;
            3'd6:    t = 8'hFE;
            default: t = 8'h03;
        endcase
        return t;
    endfunction

    // Commit-cycle strobes for a non-HALT instruction
    function automatic commit_ctrl_t decode_commit(input logic [INSTR_W-1:0] ir);
        commit_ctrl_t c;
        c = '0;
        case (alu_op_e'(ir[OPC_MSB:OPC_LSB]))
            OP_ADD, OP_XOR, OP_AND, OP_RSL, OP_MOV: begin
                c.reg_wr  = 1'b1;
                c.wr_addr = ir[FA_MSB:FA_LSB];
            end
            OP_LD: begin
                c.reg_wr  = 1'b1;
                c.wr_addr = ir[FA_MSB:FA_LSB];
                c.wb_mem  = 1'b1;
                c.mem_rd  = 1'b1;
            end
            OP_ST:   c.mem_wr = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> ROM/datapath bundle. cycleCount exists only with SEQ_CYCLE_COUNT_EN.
interface cpu_sequencer_if #(parameter int unsigned PC_W = 8);
    import cpu_sequencer_pkg::*;

    logic                start;
    logic [INSTR_W-1:0]  instr;
    logic                jumpFlag;
    logic [PC_W-1:0]     pc;
    logic [2:0]          aluOp;
    logic [REG_AW-1:0]   regRdA;
    logic [REG_AW-1:0]   regRdB;
    logic                regWrEn;
    logic [REG_AW-1:0]   regWrAddr;
    logic                wbSelMem;
    logic                memRdEn;
    logic                memWrEn;
    logic                busy;
    logic                done;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0]    cycleCount;
`endif

    modport master (
        input  start, instr, jumpFlag,
        output pc, aluOp, regRdA, regRdB, regWrEn, regWrAddr,
               wbSelMem, memRdEn, memWrEn, busy, done
`ifdef SEQ_CYCLE_COUNT_EN
        , output cycleCount
`endif
    );

    modport slave (
        output start, instr, jumpFlag,
        input  pc, aluOp, regRdA, regRdB, regWrEn, regWrAddr,
               wbSelMem, memRdEn, memWrEn, busy, done
`ifdef SEQ_CYCLE_COUNT_EN
        , input cycleCount
`endif
    );

endinterface

// File: rtl/cpu_sequencer_branch_lut.sv
// Combinational 8-entry BLQZ target table indexed by instruction field B.
module cpu_sequencer_branch_lut
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic [REG_AW-1:0] i_idx,
    output logic [PC_W-1:0]   o_target
);

    assign o_target = PC_W'(branch_target(i_idx));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/COMMIT instruction sequencer for the 8-bit datapath.
// Optional cycle counter output enabled by defining SEQ_CYCLE_COUNT_EN.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    cpu_sequencer_if.master bus
);

    seq_state_e          r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    alu_op_e             r_alu_op;
    logic [REG_AW-1:0]   r_rd_a;
    logic [REG_AW-1:0]   r_rd_b;
    commit_ctrl_t        r_ctrl;
    logic                r_busy;
    logic                r_done;

    alu_op_e             w_fetch_op;
    logic                w_ir_is_blqz;
    logic [PC_W-1:0]     w_branch_target;

    assign w_fetch_op   = alu_op_e'(bus.instr[OPC_MSB:OPC_LSB]);
    assign w_ir_is_blqz = (alu_op_e'(r_ir[OPC_MSB:OPC_LSB]) == OP_BLQZ);

    cpu_sequencer_branch_lut #(.PC_W(PC_W)) u_branch_lut (
        .i_idx    (r_ir[FB_MSB:FB_LSB]),
        .o_target (w_branch_target)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_alu_op <= OP_ADD;
            r_rd_a   <= '0;
            r_rd_b   <= '0;
            r_ctrl   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                // ALU controls are registered here so they are live throughout EXEC
                S_FETCH: begin
                    r_ir     <= bus.instr;
                    r_alu_op <= w_fetch_op;
                    r_rd_a   <= bus.instr[FA_MSB:FA_LSB];
                    r_rd_b   <= (w_fetch_op == OP_BLQZ) ? REG_AW'(0) : bus.instr[FB_MSB:FB_LSB];
                    r_done   <= (bus.instr == HALT_WORD);
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_ir == HALT_WORD) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ctrl  <= decode_commit(r_ir);
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_ctrl  <= '0;
                    r_pc    <= (w_ir_is_blqz && bus.jumpFlag) ? w_branch_target : r_pc + PC_W'(1);
                    r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0] r_cycle_count;

    // Counts busy cycles of the current run, saturating
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_cycle_count <= '0;
        end else if (r_busy && r_cycle_count != {CNT_W{1'b1}}) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

    assign bus.cycleCount = r_cycle_count;
`endif

    // Strobes are masked by reset so an aborted COMMIT never reaches the datapath
    assign bus.pc        = r_pc;
    assign bus.aluOp     = r_alu_op;
    assign bus.regRdA    = r_rd_a;
    assign bus.regRdB    = r_rd_b;
    assign bus.regWrEn   = r_ctrl.reg_wr & ~reset;
    assign bus.regWrAddr = r_ctrl.wr_addr;
    assign bus.wbSelMem  = r_ctrl.wb_mem;
    assign bus.memRdEn   = r_ctrl.mem_rd & ~reset;
    assign bus.memWrEn   = r_ctrl.mem_wr & ~reset;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done & ~reset;

endmodule
